// File: rtl/inst_ram_responder_pkg.sv
// Shared constants, response bundle type and byte-lane merge helper for the
// instruction-RAM responder.
package inst_ram_responder_pkg;

   localparam logic [31:0] INST_RAM_NOP          = 32'h03400000;
   localparam logic [31:0] INST_RAM_DEFAULT_BASE = 32'h1c000000;
   localparam int          INST_RAM_MAX_LATENCY  = 4;
   localparam int          INST_RAM_RESP_W       = 34;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] data;
   } inst_ram_resp_t;

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
      logic [31:0] result;
      result = old_word;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) result[8*i +: 8] = new_word[8*i +: 8];
      end
      return result;
   endfunction

endpackage

// File: rtl/inst_ram_rd_pipe.sv
// Fixed-length delay line of {valid, err, data} response bundles with its own
// asynchronous active-low clear.
module inst_ram_rd_pipe
   import inst_ram_responder_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic           clk,
   input  logic           resetn,
   input  inst_ram_resp_t in_resp,
   output inst_ram_resp_t out_resp
);

   inst_ram_resp_t stage [LATENCY];

   // NOTE: non-blocking assignments make every stage sample the old value of
   // its predecessor, so the shift happens in one step regardless of order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
      end else begin
         stage[0] <= in_resp;
         for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
      end
   end

   assign out_resp = stage[LATENCY-1];

endmodule

// File: rtl/inst_ram_responder.sv
// Instruction-RAM responder: word array, address checking and a fixed read
// latency. Define INST_RAM_WRITE_THROUGH_EN to make writes return the merged word.
module inst_ram_responder
   import inst_ram_responder_pkg::*;
#(
   parameter int          DEPTH        = 16384,
   parameter logic [31:0] BASE_ADDR    = INST_RAM_DEFAULT_BASE,
   parameter int          READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_ram_en,
   input  logic [31:0] inst_ram_addr,
   input  logic [3:0]  inst_ram_w_en,
   input  logic [31:0] inst_ram_w_data,
   output logic [31:0] inst_ram_r_data,
   output logic        inst_ram_r_valid,
   output logic        inst_ram_err
);

   localparam int          IDX_W = $clog2(DEPTH);
   localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

   logic [31:0]      mem [DEPTH];
   logic [31:0]      offset;
   logic [IDX_W-1:0] index;
   logic             in_range;
   logic             misaligned;
   logic             is_write;
   logic [31:0]      merged;
   inst_ram_resp_t   req_resp;
   inst_ram_resp_t   out_resp;

   // NOTE: every signal gets a default before any branch so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      offset     = inst_ram_addr - BASE_ADDR;
      in_range   = offset < SPAN;
      index      = offset[IDX_W+1:2];
      misaligned = |inst_ram_addr[1:0];
      is_write   = |inst_ram_w_en;
      merged     = merge_lanes(mem[index], inst_ram_w_data, inst_ram_w_en);
      req_resp   = '0;
      if (inst_ram_en) begin
         req_resp.err = !in_range || misaligned;
`ifdef INST_RAM_WRITE_THROUGH_EN
         req_resp.valid = 1'b1;
         if (!in_range)     req_resp.data = INST_RAM_NOP;
         else if (is_write) req_resp.data = merged;
         else               req_resp.data = mem[index];
`else
         // Writes only mark the error slot; they never raise r_valid.
         req_resp.valid = !is_write;
         if (!is_write) req_resp.data = in_range ? mem[index] : INST_RAM_NOP;
`endif
      end
   end

   // NOTE: the array has no reset; its contents survive resetn by design.
   always_ff @(posedge clk) begin
      if (inst_ram_en && is_write && in_range) mem[index] <= merged;
   end

   inst_ram_rd_pipe #(
      .LATENCY (READ_LATENCY)
   ) u_rd_pipe (
      .clk      (clk),
      .resetn   (resetn),
      .in_resp  (req_resp),
      .out_resp (out_resp)
   );

   assign inst_ram_r_data  = out_resp.data;
   assign inst_ram_r_valid = out_resp.valid;
   assign inst_ram_err     = out_resp.err;

endmodule

// File: tb/tb_inst_ram_responder.sv
// Directed bench: three responders (latency 1, 3, 4) share one stimulus stream;
// a vector table checks latency 1, hand sequences cover pipelining and reset.
module tb_inst_ram_responder;

`ifdef INST_RAM_WRITE_THROUGH_EN
   localparam logic WT = 1'b1;
`else
   localparam logic WT = 1'b0;
`endif
   localparam logic [31:0] NOP = 32'h03400000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        en;
   logic [31:0] addr;
   logic [3:0]  w_en;
   logic [31:0] w_data;

   logic [31:0] a_data, b_data, c_data;
   logic        a_valid, b_valid, c_valid;
   logic        a_err, b_err, c_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   inst_ram_responder #(.READ_LATENCY(1)) dut_a (
      .clk(clk), .resetn(resetn), .inst_ram_en(en), .inst_ram_addr(addr),
      .inst_ram_w_en(w_en), .inst_ram_w_data(w_data), .inst_ram_r_data(a_data),
      .inst_ram_r_valid(a_valid), .inst_ram_err(a_err));

   inst_ram_responder #(.READ_LATENCY(3)) dut_b (
      .clk(clk), .resetn(resetn), .inst_ram_en(en), .inst_ram_addr(addr),
      .inst_ram_w_en(w_en), .inst_ram_w_data(w_data), .inst_ram_r_data(b_data),
      .inst_ram_r_valid(b_valid), .inst_ram_err(b_err));

   inst_ram_responder #(.READ_LATENCY(4)) dut_c (
      .clk(clk), .resetn(resetn), .inst_ram_en(en), .inst_ram_addr(addr),
      .inst_ram_w_en(w_en), .inst_ram_w_data(w_data), .inst_ram_r_data(c_data),
      .inst_ram_r_valid(c_valid), .inst_ram_err(c_err));

   typedef struct {
      logic        en;
      logic [31:0] addr;
      logic [3:0]  w_en;
      logic [31:0] w_data;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive on the falling edge, then return just after the next rising edge.
   task automatic step(input logic e, input logic [31:0] a, input logic [3:0] we,
                       input logic [31:0] wd);
      @(negedge clk);
      en = e; addr = a; w_en = we; w_data = wd;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] words [3];

   initial begin
      vecs[0]  = '{1'b1, 32'h1c000010, 4'hf,    32'hdeadbeef, WT,   32'hdeadbeef, 1'b0};
      vecs[1]  = '{1'b1, 32'h1c000010, 4'h0,    32'h0,        1'b1, 32'hdeadbeef, 1'b0};
      vecs[2]  = '{1'b1, 32'h1c000010, 4'b0101, 32'h11223344, WT,   32'hde22be44, 1'b0};
      vecs[3]  = '{1'b1, 32'h1c000010, 4'h0,    32'h0,        1'b1, 32'hde22be44, 1'b0};
      vecs[4]  = '{1'b1, 32'h1c000000, 4'hf,    32'ha0a0a0a0, WT,   32'ha0a0a0a0, 1'b0};
      vecs[5]  = '{1'b1, 32'h1c000004, 4'hf,    32'hb1b1b1b1, WT,   32'hb1b1b1b1, 1'b0};
      vecs[6]  = '{1'b1, 32'h1c000008, 4'hf,    32'hc2c2c2c2, WT,   32'hc2c2c2c2, 1'b0};
      vecs[7]  = '{1'b1, 32'h1c010000, 4'h0,    32'h0,        1'b1, NOP,          1'b1};
      vecs[8]  = '{1'b1, 32'h1c000006, 4'h0,    32'h0,        1'b1, 32'hb1b1b1b1, 1'b1};
      vecs[9]  = '{1'b1, 32'h1c010000, 4'hf,    32'h55555555, WT,   NOP,          1'b1};
      vecs[10] = '{1'b1, 32'h1c000020, 4'hf,    32'h12345678, WT,   32'h12345678, 1'b0};
      vecs[11] = '{1'b1, 32'h1c000020, 4'b0011, 32'h0000abcd, WT,   32'h1234abcd, 1'b0};
      vecs[12] = '{1'b1, 32'h1c000020, 4'h0,    32'h0,        1'b1, 32'h1234abcd, 1'b0};
      vecs[13] = '{1'b0, 32'h1c000020, 4'h0,    32'h0,        1'b0, 32'h0,        1'b0};
      vecs[14] = '{1'b1, 32'h1bfffffc, 4'h0,    32'h0,        1'b1, NOP,          1'b1};
      vecs[15] = '{1'b1, 32'h1c00fffc, 4'hf,    32'h7e7e7e7e, WT,   32'h7e7e7e7e, 1'b0};
      vecs[16] = '{1'b1, 32'h1c00fffc, 4'h0,    32'h0,        1'b1, 32'h7e7e7e7e, 1'b0};
      words[0] = 32'ha0a0a0a0;
      words[1] = 32'hb1b1b1b1;
      words[2] = 32'hc2c2c2c2;

      resetn = 1'b0; en = 1'b0; addr = '0; w_en = '0; w_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset r_valid", 32'(a_valid), 32'h0);
      check("reset r_data",  a_data,       32'h0);
      check("reset err",     32'(a_err),   32'h0);
      @(negedge clk);
      resetn = 1'b1;

      // Latency 1: each row's response appears right after its own edge.
      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].en, vecs[i].addr, vecs[i].w_en, vecs[i].w_data);
         check($sformatf("vec%0d r_valid", i), 32'(a_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d err", i),     32'(a_err),   32'(vecs[i].exp_err));
         if (vecs[i].exp_valid)
            check($sformatf("vec%0d r_data", i), a_data, vecs[i].exp_data);
      end

      repeat (4) step(1'b0, 32'h0, 4'h0, 32'h0);

      // Back-to-back reads; latency 3 and 4 must stream them in order.
      for (int k = 0; k < 8; k++) begin
         if (k < 3) step(1'b1, 32'h1c000000 + 32'(4 * k), 4'h0, 32'h0);
         else       step(1'b0, 32'h0, 4'h0, 32'h0);
         check($sformatf("lat3 k%0d r_valid", k), 32'(b_valid), 32'(k >= 2 && k <= 4));
         if (k >= 2 && k <= 4) check($sformatf("lat3 k%0d r_data", k), b_data, words[k-2]);
         check($sformatf("lat4 k%0d r_valid", k), 32'(c_valid), 32'(k >= 3 && k <= 5));
         if (k >= 3 && k <= 5) check($sformatf("lat4 k%0d r_data", k), c_data, words[k-3]);
      end

      // Four reads in flight on latency 4, then an asynchronous reset pulse.
      for (int k = 0; k < 4; k++) step(1'b1, 32'h1c000000 + 32'(4 * (k % 3)), 4'h0, 32'h0);
      check("inflight lat4 r_valid", 32'(c_valid), 32'h1);
      check("inflight lat4 r_data",  c_data,       32'ha0a0a0a0);
      #1 resetn = 1'b0;
      en = 1'b0;
      #1;
      check("async reset lat4 r_valid", 32'(c_valid), 32'h0);
      check("async reset lat4 r_data",  c_data,       32'h0);
      check("async reset lat3 r_valid", 32'(b_valid), 32'h0);
      check("async reset lat1 err",     32'(a_err),   32'h0);
      #1 resetn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 32'h0, 4'h0, 32'h0);
         check($sformatf("post reset k%0d lat4 r_valid", k), 32'(c_valid), 32'h0);
         check($sformatf("post reset k%0d lat3 r_valid", k), 32'(b_valid), 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
